// File: rtl/gpio_int.sv
// gpio_int -- GPIO interface stage.
//
// Drives output pads from the level/direction registers. Watches interrupt-
// enabled input pins for changes. A qualified change snapshots all 24 pins,
// tags the snapshot with the global event counter and pulses incr_ctr. The
// block then wins slave-bus arbitration and sends one 4-byte event message:
//   byte0 {0,tag}, byte1 {0,pins[23:16]}, byte2 {0,pins[15:8]}, byte3 {1,pins[7:0]}
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   GPIO                pads; bit i driven with gpio_level[i] when gpio_direction[i]=1
//   gpio_level          output level per pin
//   gpio_direction      1 = output, 0 = input
//   gpio_int_enable     1 = input changes on this pin raise an event
//   global_counter      time tag for captured events
//   incr_ctr            one-cycle pulse per captured event
//   sl_arb_request      slave-bus request
//   sl_arb_grant        slave-bus grant
//   sl_addr             MSG_ADDR while sending and granted, else high-Z
//   sl_data             [7:0] byte, [8] last-byte flag; high-Z when not driving
//   sl_tail             9'h000 while driving, else high-Z
//   sl_latch_tail       0 while driving, else high-Z
module gpio_int #(
   parameter int         NUM_PINS   = 24,
   parameter logic [8:0] MSG_ADDR   = 9'h067,
   parameter int         ARM_CYCLES = 3
) (
   input  logic                clk,
   input  logic                reset,
   inout  wire  [NUM_PINS-1:0] GPIO,
   input  logic [NUM_PINS-1:0] gpio_level,
   input  logic [NUM_PINS-1:0] gpio_direction,
   input  logic [NUM_PINS-1:0] gpio_int_enable,
   input  logic [7:0]          global_counter,
   output logic                incr_ctr,
   output logic                sl_arb_request,
   input  logic                sl_arb_grant,
   output wire  logic [8:0]    sl_addr,
   output wire  logic [8:0]    sl_data,
   output wire  logic [8:0]    sl_tail,
   output wire  logic          sl_latch_tail
);

   localparam int ARM_W = $clog2(ARM_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, REQ, SEND} state_t;

   state_t              state;
   logic [NUM_PINS-1:0] s1, s2, s3;
   logic [NUM_PINS-1:0] snap;
   logic [7:0]          tag;
   logic [1:0]          idx;
   logic                pend;
   logic [ARM_W-1:0]    arm_cnt;
   logic                armed;
   logic [NUM_PINS-1:0] chg;
   logic                chg_any;
   logic                drive;
   logic [8:0]          msg_byte;

   // Pad drivers: purely combinational so pins follow config even in reset.
   for (genvar i = 0; i < NUM_PINS; i++) begin : g_pad
      assign GPIO[i] = gpio_direction[i] ? gpio_level[i] : 1'bz;
   end

   // s1 is the metastability stage; edges are detected between s2 and s3.
   // Until armed, the sync chain is still filling from its reset value, so a
   // pin that is already high at reset release must not look like a change.
   assign armed   = (arm_cnt == ARM_W'(ARM_CYCLES));
   assign chg     = (s2 ^ s3) & gpio_int_enable & ~gpio_direction;
   assign chg_any = armed && (|chg);

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         s1             <= '0;
         s2             <= '0;
         s3             <= '0;
         snap           <= '0;
         tag            <= '0;
         idx            <= '0;
         pend           <= 1'b0;
         arm_cnt        <= '0;
         incr_ctr       <= 1'b0;
         sl_arb_request <= 1'b0;
      end else begin
         s1       <= GPIO;
         s2       <= s1;
         s3       <= s2;
         incr_ctr <= 1'b0;
         if (!armed) arm_cnt <= arm_cnt + 1'b1;

         case (state)
            IDLE: begin
               if (chg_any || pend) begin
                  snap           <= s2;
                  tag            <= global_counter;
                  incr_ctr       <= 1'b1;
                  pend           <= 1'b0;
                  sl_arb_request <= 1'b1;
                  state          <= REQ;
               end
            end
            REQ: begin
               // Changes during a message collapse into one follow-up capture.
               if (chg_any) pend <= 1'b1;
               if (sl_arb_grant) begin
                  idx   <= '0;
                  state <= SEND;
               end
            end
            SEND: begin
               if (chg_any) pend <= 1'b1;
               // Grant low stalls: idx holds, bus floats, request stays up.
               if (sl_arb_grant) begin
                  if (idx == 2'd3) begin
                     sl_arb_request <= 1'b0;
                     state          <= IDLE;
                  end else begin
                     idx <= idx + 2'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      msg_byte = 9'h000;
      case (idx)
         2'd0: msg_byte = {1'b0, tag};
         2'd1: msg_byte = {1'b0, snap[23:16]};
         2'd2: msg_byte = {1'b0, snap[15:8]};
         2'd3: msg_byte = {1'b1, snap[7:0]};
         default: msg_byte = 9'h000;
      endcase
   end

   // Bus is shared with the other slave producers: drive only in a granted
   // SEND cycle, float otherwise.
   assign drive         = (state == SEND) && sl_arb_grant;
   assign sl_addr       = drive ? MSG_ADDR : 9'bz;
   assign sl_data       = drive ? msg_byte : 9'bz;
   assign sl_tail       = drive ? 9'h000   : 9'bz;
   assign sl_latch_tail = drive ? 1'b0     : 1'bz;

endmodule

// File: tb/tb_gpio_int.sv
// Testbench for gpio_int. Shared nets carry pullups, so a floating (high-Z)
// bus or pad reads back as all ones.
module tb_gpio_int;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [23:0] gpio_level, gpio_direction, gpio_int_enable;
   logic [7:0]  global_counter;
   logic        sl_arb_grant;
   logic [23:0] tb_oe, tb_val;
   wire  [23:0] GPIO;
   wire         incr_ctr, sl_arb_request;
   wire  [8:0]  sl_addr, sl_data, sl_tail;
   wire         sl_latch_tail;

   for (genvar i = 0; i < 24; i++) begin : g_tb_pad
      assign GPIO[i] = tb_oe[i] ? tb_val[i] : 1'bz;
      pullup (GPIO[i]);
   end
   for (genvar i = 0; i < 9; i++) begin : g_tb_bus
      pullup (sl_addr[i]);
      pullup (sl_data[i]);
      pullup (sl_tail[i]);
   end
   pullup (sl_latch_tail);

   gpio_int dut (
      .clk             (clk),
      .reset           (reset),
      .GPIO            (GPIO),
      .gpio_level      (gpio_level),
      .gpio_direction  (gpio_direction),
      .gpio_int_enable (gpio_int_enable),
      .global_counter  (global_counter),
      .incr_ctr        (incr_ctr),
      .sl_arb_request  (sl_arb_request),
      .sl_arb_grant    (sl_arb_grant),
      .sl_addr         (sl_addr),
      .sl_data         (sl_data),
      .sl_tail         (sl_tail),
      .sl_latch_tail   (sl_latch_tail)
   );

   int errors = 0;
   int checks = 0;
   int bytes_seen = 0;
   int incr_cnt = 0;
   logic [8:0] exp_q[$];

   // Scoreboard: every granted, driven bus cycle is one byte transfer.
   always @(negedge clk) begin
      if (!reset && sl_arb_grant && sl_latch_tail === 1'b0) begin
         logic [8:0] e;
         bytes_seen++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_byte: got data=%h addr=%h, none expected", sl_data, sl_addr);
         end else begin
            e = exp_q.pop_front();
            if (sl_data !== e || sl_addr !== 9'h067 || sl_tail !== 9'h000) begin
               errors++;
               $display("FAIL msg_byte: got data=%h addr=%h tail=%h, want data=%h addr=067 tail=000",
                        sl_data, sl_addr, sl_tail, e);
            end
         end
      end
      if (!reset && incr_ctr === 1'b1) incr_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_msg(input logic [7:0] tg, input logic [23:0] pins);
      exp_q.push_back({1'b0, tg});
      exp_q.push_back({1'b0, pins[23:16]});
      exp_q.push_back({1'b0, pins[15:8]});
      exp_q.push_back({1'b1, pins[7:0]});
   endtask

   task automatic wait_drain(input int max);
      for (int i = 0; i < max && exp_q.size() != 0; i++) @(negedge clk);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick(3);
      checks++;
      if ({incr_ctr, sl_arb_request} !== 2'b00) begin
         errors++;
         $display("FAIL reset_ctl: got incr/req=%b, want 00", {incr_ctr, sl_arb_request});
      end
      checks++;
      if ({sl_addr, sl_data, sl_tail, sl_latch_tail} !== {9'h1FF, 9'h1FF, 9'h1FF, 1'b1}) begin
         errors++;
         $display("FAIL reset_bus: got addr=%h data=%h tail=%h lt=%b, want all floating",
                  sl_addr, sl_data, sl_tail, sl_latch_tail);
      end
      reset = 1'b0;
      tick(6);
   endtask

   task automatic test_output_drive;
      tb_oe = 24'h0;
      gpio_direction = 24'h0000FF;
      gpio_level = 24'h0000A5;
      tick(1);
      checks++;
      if (GPIO[7:0] !== 8'hA5) begin
         errors++;
         $display("FAIL drive_low: got %h, want a5", GPIO[7:0]);
      end
      checks++;
      if (GPIO[23:8] !== 16'hFFFF) begin
         errors++;
         $display("FAIL drive_hiz: got %h, want ffff (floating)", GPIO[23:8]);
      end
      gpio_level = 24'h00005A;
      tick(1);
      checks++;
      if (GPIO[7:0] !== 8'h5A) begin
         errors++;
         $display("FAIL drive_follow: got %h, want 5a", GPIO[7:0]);
      end
      gpio_direction = 24'h0;
      gpio_level = 24'h0;
      tb_val = 24'h0;
      tb_oe = 24'hFFFFFF;
      tick(5);
   endtask

   task automatic test_single;
      int base;
      gpio_int_enable = 24'h000020;
      global_counter = 8'h3C;
      sl_arb_grant = 1'b1;
      tick(3);
      base = incr_cnt;
      tb_val[5] = 1'b1;
      push_msg(8'h3C, tb_val);
      tick(1);
      checks++;
      if ({incr_ctr, sl_arb_request} !== 2'b00) begin
         errors++;
         $display("FAIL single_e0: got incr/req=%b, want 00", {incr_ctr, sl_arb_request});
      end
      tick(1);
      checks++;
      if ({incr_ctr, sl_arb_request} !== 2'b00) begin
         errors++;
         $display("FAIL single_e1: got incr/req=%b, want 00", {incr_ctr, sl_arb_request});
      end
      tick(1);
      checks++;
      if ({incr_ctr, sl_arb_request} !== 2'b11) begin
         errors++;
         $display("FAIL single_e2: got incr/req=%b, want 11", {incr_ctr, sl_arb_request});
      end
      tick(1);
      checks++;
      if ({incr_ctr, sl_arb_request} !== 2'b01) begin
         errors++;
         $display("FAIL single_pulse: got incr/req=%b, want 01", {incr_ctr, sl_arb_request});
      end
      wait_drain(20);
      tick(2);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL single_drain: %0d bytes left, want 0", exp_q.size());
      end
      checks++;
      if (sl_arb_request !== 1'b0 || incr_cnt - base != 1) begin
         errors++;
         $display("FAIL single_end: got req=%b incr=%0d, want req=0 incr=1",
                  sl_arb_request, incr_cnt - base);
      end
   endtask

   task automatic test_masking;
      int base;
      logic req_seen;
      gpio_int_enable = 24'h000080;
      gpio_direction = 24'h000080;
      tb_oe = ~24'h000080;
      gpio_level = 24'h0;
      tick(5);
      base = incr_cnt;
      req_seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tb_val[6] = ~tb_val[6];
         gpio_level[7] = ~gpio_level[7];
         for (int j = 0; j < 3; j++) begin
            tick(1);
            if (sl_arb_request !== 1'b0) req_seen = 1'b1;
         end
      end
      checks++;
      if (req_seen !== 1'b0 || incr_cnt != base) begin
         errors++;
         $display("FAIL masking: got req_seen=%b incr=%0d, want 0 and 0", req_seen, incr_cnt - base);
      end
      gpio_int_enable = 24'h0;
      tb_val[7] = gpio_level[7];
      tb_oe = 24'hFFFFFF;
      gpio_direction = 24'h0;
      tick(5);
   endtask

   task automatic test_coalesce;
      int base;
      gpio_int_enable = 24'h000001;
      global_counter = 8'h51;
      tick(3);
      base = incr_cnt;
      tb_val[0] = 1'b1;
      push_msg(8'h51, tb_val);
      for (int i = 0; i < 10 && incr_ctr !== 1'b1; i++) tick(1);
      checks++;
      if (incr_ctr !== 1'b1) begin
         errors++;
         $display("FAIL coalesce_start: incr_ctr=%b, want 1 within 10 cycles", incr_ctr);
      end
      // Three toggles while the first message is in flight.
      global_counter = 8'h52;
      tb_val[0] = 1'b0;
      tick(1);
      tb_val[0] = 1'b1;
      tick(1);
      tb_val[0] = 1'b0;
      push_msg(8'h52, tb_val);
      wait_drain(40);
      tick(8);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL coalesce_drain: %0d bytes left, want 0", exp_q.size());
      end
      checks++;
      if (incr_cnt - base != 2 || sl_arb_request !== 1'b0) begin
         errors++;
         $display("FAIL coalesce_count: got incr=%0d req=%b, want incr=2 req=0",
                  incr_cnt - base, sl_arb_request);
      end
   endtask

   task automatic test_stall;
      int b0;
      logic bad;
      gpio_int_enable = 24'h000002;
      global_counter = 8'h77;
      tick(3);
      b0 = bytes_seen;
      tb_val[1] = 1'b1;
      push_msg(8'h77, tb_val);
      for (int i = 0; i < 20 && bytes_seen < b0 + 2; i++) @(posedge clk);
      #1;
      sl_arb_grant = 1'b0;
      checks++;
      if (bytes_seen != b0 + 2) begin
         errors++;
         $display("FAIL stall_start: got %0d bytes, want 2", bytes_seen - b0);
      end
      bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (sl_data !== 9'h1FF || sl_addr !== 9'h1FF || sl_arb_request !== 1'b1) bad = 1'b1;
      end
      checks++;
      if (bad !== 1'b0) begin
         errors++;
         $display("FAIL stall_hold: data=%h addr=%h req=%b, want floating bus and req=1",
                  sl_data, sl_addr, sl_arb_request);
      end
      @(posedge clk);
      #1;
      sl_arb_grant = 1'b1;
      wait_drain(20);
      tick(2);
      checks++;
      if (exp_q.size() != 0 || bytes_seen != b0 + 4) begin
         errors++;
         $display("FAIL stall_resume: left=%0d bytes=%0d, want left=0 bytes=4",
                  exp_q.size(), bytes_seen - b0);
      end
   endtask

   task automatic test_reset_mid;
      int b0, base;
      logic req_seen;
      gpio_int_enable = 24'h000004;
      global_counter = 8'h99;
      tick(3);
      b0 = bytes_seen;
      tb_val[2] = 1'b1;
      exp_q.push_back({1'b0, 8'h99});
      exp_q.push_back({1'b0, tb_val[23:16]});
      for (int i = 0; i < 20 && bytes_seen < b0 + 2; i++) @(posedge clk);
      #1;
      reset = 1'b1;
      tb_val = 24'hFFFFFF;
      gpio_int_enable = 24'hFFFFFF;
      tick(2);
      checks++;
      if ({sl_arb_request, sl_addr, sl_data, sl_tail, sl_latch_tail} !==
          {1'b0, 9'h1FF, 9'h1FF, 9'h1FF, 1'b1} || exp_q.size() != 0) begin
         errors++;
         $display("FAIL reset_mid: req=%b addr=%h data=%h tail=%h lt=%b left=%0d, want idle and floating",
                  sl_arb_request, sl_addr, sl_data, sl_tail, sl_latch_tail, exp_q.size());
      end
      tick(1);
      reset = 1'b0;
      base = incr_cnt;
      req_seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         if (sl_arb_request !== 1'b0) req_seen = 1'b1;
      end
      checks++;
      if (req_seen !== 1'b0 || incr_cnt != base) begin
         errors++;
         $display("FAIL arm_mask: req_seen=%b incr=%0d, want 0 and 0", req_seen, incr_cnt - base);
      end
   endtask

   task automatic test_back_to_back;
      int base;
      base = incr_cnt;
      global_counter = 8'hC3;
      tb_val[3] = 1'b0;
      push_msg(8'hC3, tb_val);
      wait_drain(30);
      tick(3);
      checks++;
      if (exp_q.size() != 0 || incr_cnt - base != 1) begin
         errors++;
         $display("FAIL post_arm: left=%0d incr=%0d, want left=0 incr=1", exp_q.size(), incr_cnt - base);
      end
   endtask

   initial begin
      reset = 1'b1;
      gpio_level = '0;
      gpio_direction = '0;
      gpio_int_enable = '0;
      global_counter = '0;
      sl_arb_grant = 1'b0;
      tb_oe = 24'hFFFFFF;
      tb_val = '0;
      test_reset;
      test_output_drive;
      test_single;
      test_masking;
      test_coalesce;
      test_stall;
      test_reset_mid;
      test_back_to_back;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gpio_int.md
# gpio_int

GPIO interface stage for the ICE board: drives output pins from configuration registers and watches interrupt-enabled input pins for changes. On a qualified change it snapshots all 24 pins, bumps the global event counter, wins slave-bus arbitration and emits one 4-byte GPIO event message upstream to the bus controller. Sits beside the other slave-bus producers (MBus, PMU, EIN) on arbitration slot 4.

## Interface
- NUM_PINS, 24, GPIO width; message layout below is fixed for 24.
- MSG_ADDR, 9'h067, value driven on sl_addr while granted (ASCII 'g').
- ARM_CYCLES, 3, cycles after reset during which change detection is masked.

- clk  in  1  system clock; the block's only clock.
- reset  in  1  synchronous, active-high.
- GPIO  inout  24  pads; bit i driven with gpio_level[i] when gpio_direction[i]=1, else high-Z.
- gpio_level  in  24  output level per pin.
- gpio_direction  in  24  1 = output, 0 = input.
- gpio_int_enable  in  24  1 = input changes on this pin raise an event.
- global_counter  in  8  time tag from the global event counter.
- incr_ctr  out  1  one-cycle pulse per captured event.
- sl_arb_request  out  1  slave-bus request.
- sl_arb_grant  in  1  slave-bus grant.
- sl_addr  out  9  MSG_ADDR while granted, else high-Z.
- sl_data  out  9  [7:0] byte, [8] last-byte flag; high-Z when not granted.
- sl_tail  out  9  9'h000 while granted, else high-Z (tail unused).
- sl_latch_tail  out  1  0 while granted, else high-Z.

## Operation
- Input path: s1 <= GPIO, s2 <= s1, s3 <= s2 every cycle. chg = (s2 ^ s3) & gpio_int_enable & ~gpio_direction, qualified only once arm counter reaches ARM_CYCLES.
- States: IDLE, REQ, SEND.
- IDLE: if chg!=0 or pend=1 -> capture snap <= s2, tag <= global_counter, incr_ctr <= 1 for one cycle, pend <= 0, go REQ.
- REQ: sl_arb_request=1; on sl_arb_grant=1 go SEND, idx=0.
- SEND: sl_arb_request=1; each cycle with grant=1 drive byte idx and advance: idx0 {0,tag}, idx1 {0,snap[23:16]}, idx2 {0,snap[15:8]}, idx3 {1,snap[7:0]}. After idx3 -> IDLE, request drops at same edge.
- Grant low in SEND: hold idx, drive high-Z, keep requesting (stall, no byte lost).
- chg!=0 while in REQ/SEND: pend <= 1 (coalesced; one follow-up message carrying pin state at its capture time). Multiple changes collapse into a single pend.
- Reset mid-message: all state cleared, request drops, buses high-Z next cycle; partial message is abandoned.

## Timing
- Reset values: incr_ctr 0, sl_arb_request 0, sl_addr/sl_data/sl_tail/sl_latch_tail high-Z, s1..s3 0, pend 0, arm counter 0, state IDLE. GPIO outputs follow direction/level combinationally even in reset.
- Pin change present before edge E: s1 at E, s2 at E+1, s3 at E+2; capture, incr_ctr and REQ at E+2 (chg evaluated in cycle E+1..E+2).
- sl_arb_request high from E+2; if grant already high, byte 0 in cycle after REQ->SEND edge; 4 consecutive data cycles with continuous grant.
- Minimum spacing between messages: 1 IDLE cycle (pend re-capture from IDLE).
- Arm: chg masked until ARM_CYCLES edges after reset deassert.

## Test plan
- Output drive: direction=24'h0000FF, level=24'h0000A5 -> GPIO[7:0]=8'hA5, GPIO[23:8] high-Z.
- Single event: int_enable[5]=1, counter=8'h3C, pin5 0->1 at E -> incr_ctr pulse at E+2, request at E+2, with grant held: sl_data 9'h03C, 9'h000, 9'h000, 9'h120, sl_addr 9'h067.
- Masking: toggle pin 6 with int_enable[6]=0, and pin 7 with direction[7]=1 -> no request, no incr_ctr.
- Coalescing: three toggles of pin 0 during SEND -> exactly one follow-up message after first, incr_ctr pulses total 2.
- Grant stall: drop grant after byte 1 for 5 cycles -> bytes 2,3 resume unchanged, data high-Z during stall.
- Reset mid-SEND after byte 1 -> request 0 and buses high-Z next cycle; pins high at reset release -> no event within ARM_CYCLES.
